// File: rtl/sevenseg_scan_ctrl.sv
// Wishbone-slave multiplexed seven-segment controller: DATA/CTRL/BLINK/STAT registers and a digit scanner.
// Optional blinking (BLINK register, frame counter, blink phase) is built when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan_ctrl #(
    parameter int          NUM_DIGITS     = 4,
    parameter int          PRESCALE       = 1000,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic [NUM_DIGITS+7:0]   io_oeb_o
);
    localparam int          PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [2:0]  IDX_MAX    = 3'(NUM_DIGITS - 1);
    localparam logic [31:0] CTRL_MASK  = 32'h0000_FF01;

    logic [31:0]   data_q, data_d;
    logic [31:0]   ctrl_q, ctrl_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic          blink_phase;
    logic          blank;

    logic          hit, accept, wr, en, slot_end, frame_end;
    logic [1:0]    reg_sel;
    logic [31:0]   rdata;
    logic [3:0]    digit;
    logic [7:0]    onehot;
    logic          unused_adr_lsb;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
        endcase
    endfunction

    // A strobe held while ack is high is not re-accepted, so back-to-back strobes ack every 2nd cycle.
    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept    = hit & ~ack_q;
    assign wr        = accept & wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];
    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign en        = ctrl_q[0];
    assign slot_end  = (presc_q == PRESC_MAX);
    assign frame_end = slot_end && (idx_q == IDX_MAX);
    assign digit     = data_q[{idx_q, 2'b00} +: 4];
    assign onehot    = 8'(1) << idx_q;

`ifdef SEVENSEG_BLINK_EN
    localparam logic [7:0] BLINK_MASK = 8'((1 << NUM_DIGITS) - 1);
    logic [7:0]  blink_q, blink_d;
    logic [7:0]  frame_q, frame_d;
    logic [31:0] blink_wr;
    logic        phase_q, phase_d;

    assign blink_phase = phase_q;
    assign blank       = phase_q & blink_q[idx_q];
    assign blink_wr    = merge_bytes({24'h0, blink_q}, wbs_dat_i, wbs_sel_i);

    always_comb begin
        blink_d = blink_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (wr && reg_sel == 2'd2) begin
            blink_d = blink_wr[7:0] & BLINK_MASK;
        end
        // Disabling the scanner also restarts the blink timing.
        if (!en) begin
            frame_d = 8'h00;
            phase_d = 1'b0;
        end else if (frame_end) begin
            frame_d = frame_q + 8'h01;
            if (frame_q == 8'hFF) phase_d = ~phase_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            blink_q <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end
`else
    assign blink_phase = 1'b0;
    assign blank       = 1'b0;
`endif

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (wr && reg_sel == 2'd0) data_d = merge_bytes(data_q, wbs_dat_i, wbs_sel_i);
        if (wr && reg_sel == 2'd1) ctrl_d = merge_bytes(ctrl_q, wbs_dat_i, wbs_sel_i) & CTRL_MASK;

        rdata = 32'h0;
        case (reg_sel)
            2'd0: rdata = data_q;
            2'd1: rdata = ctrl_q;
`ifdef SEVENSEG_BLINK_EN
            2'd2: rdata = {24'h0, blink_q};
`else
            2'd2: rdata = 32'h0;
`endif
            default: rdata = {23'h0, blink_phase, 5'h0, idx_q};
        endcase
        ack_d = accept;
        dat_d = (accept && !wbs_we_i) ? rdata : 32'h0;
    end

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!en) begin
            presc_d = '0;
            idx_d   = 3'd0;
        end else if (slot_end) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // First cycle of each slot keeps all digits dark to avoid ghosting.
        seg_d = (en && !blank) ? {ctrl_q[8 + idx_q], hex_glyph(digit)} : 8'h00;
        dig_d = (en && presc_q != '0) ? onehot[NUM_DIGITS-1:0] : '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign seg_o     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_o     = SEG_ACTIVE_LOW ? ~dig_q : dig_q;
    assign io_oeb_o  = '0;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4).
// Blink behaviour is exercised when SEVENSEG_BLINK_EN is defined, otherwise BLINK must read 0.
module tb_sevenseg_scan_ctrl;
    localparam logic [31:0] A_DATA  = 32'h3000_0000;
    localparam logic [31:0] A_CTRL  = 32'h3000_0004;
    localparam logic [31:0] A_BLINK = 32'h3000_0008;
    localparam logic [31:0] A_STAT  = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [11:0] oeb;

    int n_cmp = 0;
    int n_bad = 0;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS(4), .PRESCALE(4), .BASE_ADDR(32'h3000_0000), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .seg_o(seg), .dig_o(dig), .io_oeb_o(oeb)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the one where ack was seen (or timed out).
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output int lat,
                            output logic ack2);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0; rd = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                rd  = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        ack2 = ack;
    endtask

    task automatic test_reset;
        logic [31:0] rd; int lat; logic a2;
        n_cmp++;
        if (seg !== 8'h00 || dig !== 4'h0 || ack !== 1'b0 || dat_o !== 32'h0 || oeb !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: seg=%h dig=%b ack=%b dat=%h oeb=%h, need all 0", seg, dig, ack, dat_o, oeb);
        end
        wb_cycle(A_DATA, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0 || lat !== 1) begin
            n_bad++; $display("FAIL reset_data: got %h lat %0d, need 0 lat 1", rd, lat);
        end
        wb_cycle(A_CTRL, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h, need 0", rd); end
        wb_cycle(A_STAT, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_stat: got %h, need 0", rd); end
    endtask

    task automatic test_scan;
        logic [31:0] rd; int lat; logic a2;
        logic [7:0] exp_seg; logic [3:0] exp_dig; int k;
        wb_cycle(A_DATA, 1'b1, 32'h0000_4321, 4'hF, rd, lat, a2);
        wb_cycle(A_CTRL, 1'b1, 32'h0000_0001, 4'hF, rd, lat, a2);
        // Sample j shows the scanner state j steps after enable.
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            k = (j / 4) % 4;
            exp_seg = (k == 0) ? 8'h06 : (k == 1) ? 8'h5B : (k == 2) ? 8'h4F : 8'h66;
            exp_dig = (j % 4 == 0) ? 4'h0 : 4'(1 << k);
            n_cmp++;
            if (seg !== exp_seg || dig !== exp_dig) begin
                n_bad++;
                $display("FAIL scan_step%0d: seg=%h dig=%b, need seg=%h dig=%b", j, seg, dig, exp_seg, exp_dig);
            end
        end
        wb_cycle(A_STAT, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h1) begin n_bad++; $display("FAIL scan_stat: got %h, need 1", rd); end
    endtask

    task automatic test_dp_disable;
        logic [31:0] rd; int lat; logic a2;
        logic [7:0] exp_seg; logic [3:0] exp_dig;
        wb_cycle(A_CTRL, 1'b1, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (seg !== 8'h00 || dig !== 4'h0) begin
            n_bad++; $display("FAIL disable1_outputs: seg=%h dig=%b, need 0", seg, dig);
        end
        wb_cycle(A_DATA, 1'b1, 32'h0000_0008, 4'hF, rd, lat, a2);
        wb_cycle(A_CTRL, 1'b1, 32'h0000_0501, 4'hF, rd, lat, a2);
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (j % 4 == 1) begin
                exp_seg = (j == 1) ? 8'hFF : (j == 9) ? 8'hBF : 8'h3F;
                exp_dig = 4'(1 << (j / 4));
                n_cmp++;
                if (seg !== exp_seg || dig !== exp_dig) begin
                    n_bad++;
                    $display("FAIL dp_step%0d: seg=%h dig=%b, need seg=%h dig=%b", j, seg, dig, exp_seg, exp_dig);
                end
            end
        end
        wb_cycle(A_CTRL, 1'b1, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (seg !== 8'h00 || dig !== 4'h0) begin
            n_bad++; $display("FAIL disable2_outputs: seg=%h dig=%b, need 0", seg, dig);
        end
        wb_cycle(A_STAT, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL disable_stat: got %h, need 0", rd); end
    endtask

    task automatic test_byte_write;
        logic [31:0] rd; int lat; logic a2;
        wb_cycle(A_DATA, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, lat, a2);
        n_cmp++;
        if (lat !== 1 || a2 !== 1'b0) begin
            n_bad++; $display("FAIL bw_ack_full: lat=%0d ack_after=%b, need 1 and 0", lat, a2);
        end
        wb_cycle(A_DATA, 1'b1, 32'h0000_0000, 4'b0010, rd, lat, a2);
        n_cmp++;
        if (lat !== 1 || a2 !== 1'b0) begin
            n_bad++; $display("FAIL bw_ack_byte: lat=%0d ack_after=%b, need 1 and 0", lat, a2);
        end
        wb_cycle(A_DATA, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'hFFFF_00FF || lat !== 1 || a2 !== 1'b0) begin
            n_bad++; $display("FAIL bw_readback: got %h lat=%0d ack_after=%b, need ffff00ff 1 0", rd, lat, a2);
        end
    endtask

    task automatic test_miss;
        logic [31:0] rd; int lat; logic a2; int acks;
        acks = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0010; dat_i = 32'h0; sel = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (acks !== 0) begin n_bad++; $display("FAIL miss_ack: got %0d acks, need 0", acks); end
        wb_cycle(A_DATA, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'hFFFF_00FF) begin n_bad++; $display("FAIL miss_data: got %h, need ffff00ff", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; int lat; logic a2;
        logic [3:0] acks; logic [31:0] dats[4];
        wb_cycle(A_DATA, 1'b1, 32'hA5C3_1234, 4'hF, rd, lat, a2);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_DATA; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks[i] = ack;
            dats[i] = dat_o;
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (acks !== 4'b0101) begin n_bad++; $display("FAIL b2b_acks: got %b, need 0101", acks); end
        n_cmp++;
        if (dats[0] !== 32'hA5C3_1234 || dats[1] !== 32'h0 || dats[2] !== 32'hA5C3_1234 || dats[3] !== 32'h0) begin
            n_bad++;
            $display("FAIL b2b_data: got %h %h %h %h, need a5c31234 0 a5c31234 0", dats[0], dats[1], dats[2], dats[3]);
        end
    endtask

    task automatic test_blink;
        logic [31:0] rd; int lat; logic a2;
`ifdef SEVENSEG_BLINK_EN
        logic [7:0] exp_seg; logic [3:0] exp_dig; logic chk;
        wb_cycle(A_BLINK, 1'b1, 32'hFFFF_FFF2, 4'hF, rd, lat, a2);
        wb_cycle(A_BLINK, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h2) begin n_bad++; $display("FAIL blink_reg: got %h, need 2", rd); end
        wb_cycle(A_DATA, 1'b1, 32'h0000_4321, 4'hF, rd, lat, a2);
        wb_cycle(A_CTRL, 1'b1, 32'h0000_0001, 4'hF, rd, lat, a2);
        for (int j = 0; j <= 8197; j++) begin
            if (j > 0) @(negedge clk);
            chk = 1'b1;
            exp_seg = 8'h00; exp_dig = 4'h0;
            case (j)
                4084:    begin exp_seg = 8'h5B; exp_dig = 4'h0; end
                4097:    begin exp_seg = 8'h06; exp_dig = 4'h1; end
                4101:    begin exp_seg = 8'h00; exp_dig = 4'h2; end
                4106:    begin exp_seg = 8'h4F; exp_dig = 4'h4; end
                8197:    begin exp_seg = 8'h5B; exp_dig = 4'h2; end
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_cmp++;
                if (seg !== exp_seg || dig !== exp_dig) begin
                    n_bad++;
                    $display("FAIL blink_step%0d: seg=%h dig=%b, need seg=%h dig=%b", j, seg, dig, exp_seg, exp_dig);
                end
            end
        end
`else
        wb_cycle(A_BLINK, 1'b1, 32'h0000_000F, 4'hF, rd, lat, a2);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL blink_wr_ack: lat=%0d, need 1", lat); end
        wb_cycle(A_BLINK, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL blink_reads0: got %h, need 0", rd); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; int lat; logic a2;
        wb_cycle(A_CTRL, 1'b1, 32'h0000_0001, 4'hF, rd, lat, a2);
        repeat (6) @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
        @(posedge clk);
        #2;
        n_cmp++;
        if (ack !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_ack: ack=%b, need 1", ack); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 1'b0 || seg !== 8'h00 || dig !== 4'h0 || dat_o !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_async: ack=%b seg=%h dig=%b dat=%h, need all 0", ack, seg, dig, dat_o);
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        // A write strobed just before reset must be lost.
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = A_DATA; dat_i = 32'h1234_5678; sel = 4'hF;
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        wb_cycle(A_STAT, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_stat: got %h, need 0", rd); end
        wb_cycle(A_DATA, 1'b0, 32'h0, 4'hF, rd, lat, a2);
        n_cmp++;
        if (rd !== 32'h0) begin n_bad++; $display("FAIL rstmid_data: got %h, need 0", rd); end
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_scan;
        test_dp_disable;
        test_byte_write;
        test_miss;
        test_back_to_back;
        test_blink;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
